// File: rtl/bridge_pkg.sv
// Shared types and widths for the host bridge router.
package bridge_pkg;

   localparam int BRIDGE_ADDR_W = 32;
   localparam int BRIDGE_DATA_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } bridge_rd_state_t;

   // Select index width; at least one bit so a single-slave build still has a legal vector.
   function automatic int bridge_sel_w(input int num_slaves);
      return (num_slaves > 1) ? $clog2(num_slaves) : 1;
   endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Priority address decoder: the lowest-index slave whose base/mask matches wins.
module bridge_addr_decode
   import bridge_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int SEL_W      = 2,
   parameter logic [NUM_SLAVES-1:0][BRIDGE_ADDR_W-1:0] SLAVE_BASE = '0,
   parameter logic [NUM_SLAVES-1:0][BRIDGE_ADDR_W-1:0] SLAVE_MASK = {NUM_SLAVES{32'hF000_0000}}
) (
   input  logic [BRIDGE_ADDR_W-1:0] i_addr,
   output logic [SEL_W-1:0]         o_sel,
   output logic                     o_hit
);

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      o_hit = 1'b0;
      o_sel = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((i_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
            o_hit = 1'b1;
            o_sel = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/bridge_router.sv
// Host bridge router: decodes host accesses, forwards them to one slave a cycle
// later and sequences a single outstanding read with timeout and default data.
//
//   state | meaning
//   IDLE  | no read outstanding; a hit read is forwarded, a miss read answered at once
//   WAIT  | read forwarded to r_sel; waiting for its valid or for the timeout
module bridge_router
   import bridge_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES-1:0][BRIDGE_ADDR_W-1:0] SLAVE_BASE = '0,
   parameter logic [NUM_SLAVES-1:0][BRIDGE_ADDR_W-1:0] SLAVE_MASK = {NUM_SLAVES{32'hF000_0000}},
   parameter int TIMEOUT_CYCLES = 64,
   parameter logic [BRIDGE_DATA_W-1:0] DEFAULT_DATA = 32'hDEAD_BEEF
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [BRIDGE_ADDR_W-1:0]            h_addr,
   input  logic                                h_rd,
   input  logic                                h_wr,
   input  logic [BRIDGE_DATA_W-1:0]            h_wr_data,
   output logic [BRIDGE_DATA_W-1:0]            h_rd_data,
   output logic                                h_rd_data_valid,
   output logic [BRIDGE_ADDR_W-1:0]            s_addr,
   output logic [BRIDGE_DATA_W-1:0]            s_wr_data,
   output logic [NUM_SLAVES-1:0]               s_rd,
   output logic [NUM_SLAVES-1:0]               s_wr,
   input  logic [NUM_SLAVES*BRIDGE_DATA_W-1:0] s_rd_data,
   input  logic [NUM_SLAVES-1:0]               s_rd_data_valid,
   output logic                                rd_overrun,
   output logic [15:0]                         timeout_count
);

   localparam int SEL_W = bridge_sel_w(NUM_SLAVES);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [SEL_W-1:0]                          w_sel;
   logic                                      w_hit;
   logic [NUM_SLAVES-1:0]                     w_onehot;
   logic [NUM_SLAVES-1:0][BRIDGE_DATA_W-1:0]  w_rd_arr;

   bridge_rd_state_t          r_state;
   logic [SEL_W-1:0]          r_sel;
   logic [CNT_W-1:0]          r_cnt;
   logic [BRIDGE_DATA_W-1:0]  r_rd_data;
   logic                      r_rd_valid;
   logic [BRIDGE_ADDR_W-1:0]  r_s_addr;
   logic [BRIDGE_DATA_W-1:0]  r_s_wr_data;
   logic [NUM_SLAVES-1:0]     r_s_rd;
   logic [NUM_SLAVES-1:0]     r_s_wr;
   logic                      r_overrun;
   logic [15:0]               r_to_cnt;

   bridge_addr_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_W      (SEL_W),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_decode (
      .i_addr (h_addr),
      .o_sel  (w_sel),
      .o_hit  (w_hit)
   );

   assign w_onehot = NUM_SLAVES'(1) << w_sel;
   assign w_rd_arr = s_rd_data;

   // Address/data and write strobes are forwarded regardless of the read FSM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s_addr    <= '0;
         r_s_wr_data <= '0;
         r_s_wr      <= '0;
      end else begin
         r_s_wr <= (h_wr && w_hit) ? w_onehot : '0;
         if (h_rd || h_wr) begin
            r_s_addr    <= h_addr;
            r_s_wr_data <= h_wr_data;
         end
      end
   end

   // Read FSM: one outstanding read, slave valid beats the timeout on the last wait cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_sel      <= '0;
         r_cnt      <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_s_rd     <= '0;
         r_overrun  <= 1'b0;
         r_to_cnt   <= '0;
      end else begin
         r_s_rd     <= '0;
         r_rd_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (h_rd) begin
                  if (w_hit) begin
                     r_s_rd  <= w_onehot;
                     r_sel   <= w_sel;
                     r_cnt   <= '0;
                     r_state <= WAIT;
                  end else begin
                     r_rd_data  <= DEFAULT_DATA;
                     r_rd_valid <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (h_rd) begin
                  r_overrun <= 1'b1;
               end
               if (s_rd_data_valid[r_sel]) begin
                  r_rd_data  <= w_rd_arr[r_sel];
                  r_rd_valid <= 1'b1;
                  r_state    <= IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  r_rd_data  <= DEFAULT_DATA;
                  r_rd_valid <= 1'b1;
                  r_state    <= IDLE;
                  if (r_to_cnt != 16'hFFFF) begin
                     r_to_cnt <= r_to_cnt + 16'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign h_rd_data       = r_rd_data;
   assign h_rd_data_valid = r_rd_valid;
   assign s_addr          = r_s_addr;
   assign s_wr_data       = r_s_wr_data;
   assign s_rd            = r_s_rd;
   assign s_wr            = r_s_wr;
   assign rd_overrun      = r_overrun;
   assign timeout_count   = r_to_cnt;

endmodule

// File: tb/tb_bridge_router.sv
// Self-checking bench for bridge_router: vector table plus hand sequences,
// read responses checked (data and arrival cycle) through a scoreboard queue.
module tb_bridge_router;

   localparam int N  = 4;
   localparam int TO = 8;

   logic              clk;
   logic              reset_n;
   logic [31:0]       h_addr;
   logic              h_rd;
   logic              h_wr;
   logic [31:0]       h_wr_data;
   logic [31:0]       h_rd_data;
   logic              h_rd_data_valid;
   logic [31:0]       s_addr;
   logic [31:0]       s_wr_data;
   logic [N-1:0]      s_rd;
   logic [N-1:0]      s_wr;
   logic [N*32-1:0]   s_rd_data;
   logic [N-1:0]      s_rd_data_valid;
   logic              rd_overrun;
   logic [15:0]       timeout_count;

   bridge_router #(
      .NUM_SLAVES     (N),
      .SLAVE_BASE     ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
      .SLAVE_MASK     ({N{32'hF000_0000}}),
      .TIMEOUT_CYCLES (TO),
      .DEFAULT_DATA   (32'hDEAD_BEEF)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .h_addr          (h_addr),
      .h_rd            (h_rd),
      .h_wr            (h_wr),
      .h_wr_data       (h_wr_data),
      .h_rd_data       (h_rd_data),
      .h_rd_data_valid (h_rd_data_valid),
      .s_addr          (s_addr),
      .s_wr_data       (s_wr_data),
      .s_rd            (s_rd),
      .s_wr            (s_wr),
      .s_rd_data       (s_rd_data),
      .s_rd_data_valid (s_rd_data_valid),
      .rd_overrun      (rd_overrun),
      .timeout_count   (timeout_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   always @(posedge clk) cyc++;

   // Slave models: answer 'delay' cycles after their s_rd; delay 0 means never.
   logic [31:0] sl_data [N];
   int          sl_delay [N];
   int          sl_pend [N];
   logic [N-1:0] sl_valid;

   assign s_rd_data       = {sl_data[3], sl_data[2], sl_data[1], sl_data[0]};
   assign s_rd_data_valid = sl_valid;

   initial begin
      sl_valid = '0;
      for (int i = 0; i < N; i++) begin
         sl_pend[i]  = 0;
         sl_delay[i] = 0;
      end
      sl_data[0] = 32'h1111_0000;
      sl_data[1] = 32'h2024_0611;
      sl_data[2] = 32'h2222_0002;
      sl_data[3] = 32'h3333_0003;
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         sl_valid[i] = 1'b0;
         if (sl_pend[i] > 0) begin
            sl_pend[i]--;
            if (sl_pend[i] == 0) sl_valid[i] = 1'b1;
         end
         if (s_rd[i]) sl_pend[i] = sl_delay[i];
      end
   end

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb_q[$];

   // Host-side monitor: every valid must match the head of the scoreboard in data and cycle.
   always @(negedge clk) begin
      if (h_rd_data_valid) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid: got data %h at cycle %0d, expected no response", h_rd_data, cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (h_rd_data !== e.data || cyc != e.due) begin
               n_err++;
               $display("FAIL rd_response: got %h at cycle %0d, expected %h at cycle %0d",
                        h_rd_data, cyc, e.data, e.due);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one strobe cycle; returns #1 after the edge that starts cycle 1.
   task automatic strobe(input logic [31:0] a, input logic rd, input logic wr,
                         input logic [31:0] wd, input logic push,
                         input logic [31:0] exp_data, input int lat);
      @(posedge clk); #1;
      h_addr = a; h_rd = rd; h_wr = wr; h_wr_data = wd;
      if (push) sb_q.push_back('{exp_data, cyc + lat});
      @(posedge clk); #1;
      h_rd = 1'b0; h_wr = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
         sb_q.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic set_delay(input int d);
      for (int i = 0; i < N; i++) sl_delay[i] = d;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [31:0] wdata;
      int          dly;
      logic [3:0]  exp_srd;
      logic [3:0]  exp_swr;
      logic [31:0] exp_data;
      int          lat;
      int          to;
   } vec_t;

   vec_t vecs [9];
   int   exp_to = 0;

   initial begin
      vecs[0] = '{32'h1000_0004, 1'b1, 1'b0, 32'h0,          1, 4'b0010, 4'b0000, 32'h2024_0611, 3, 0};
      vecs[1] = '{32'hF000_0000, 1'b1, 1'b0, 32'h0,          1, 4'b0000, 4'b0000, 32'hDEAD_BEEF, 1, 0};
      vecs[2] = '{32'h3000_0000, 1'b1, 1'b0, 32'h0,          0, 4'b1000, 4'b0000, 32'hDEAD_BEEF, 9, 1};
      vecs[3] = '{32'h2000_0008, 1'b1, 1'b0, 32'h0,          7, 4'b0100, 4'b0000, 32'h2222_0002, 9, 0};
      vecs[4] = '{32'h0000_0010, 1'b1, 1'b0, 32'h0,          2, 4'b0001, 4'b0000, 32'h1111_0000, 4, 0};
      vecs[5] = '{32'h2000_0010, 1'b0, 1'b1, 32'hA5A5_0001, 1, 4'b0000, 4'b0100, 32'h0,          0, 0};
      vecs[6] = '{32'hF000_0004, 1'b0, 1'b1, 32'h1234_5678, 1, 4'b0000, 4'b0000, 32'h0,          0, 0};
      vecs[7] = '{32'h1000_0000, 1'b1, 1'b1, 32'h0000_00AA, 1, 4'b0010, 4'b0010, 32'h2024_0611, 3, 0};
      vecs[8] = '{32'h2000_0000, 1'b1, 1'b0, 32'h0,          8, 4'b0100, 4'b0000, 32'hDEAD_BEEF, 9, 1};

      reset_n = 1'b0;
      h_addr = '0; h_rd = 1'b0; h_wr = 1'b0; h_wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_h_rd_data",  h_rd_data, 32'h0);
      chk("rst_valid",      32'(h_rd_data_valid), 32'h0);
      chk("rst_s_addr",     s_addr, 32'h0);
      chk("rst_s_wr_data",  s_wr_data, 32'h0);
      chk("rst_s_rd",       32'(s_rd), 32'h0);
      chk("rst_s_wr",       32'(s_wr), 32'h0);
      chk("rst_overrun",    32'(rd_overrun), 32'h0);
      chk("rst_timeouts",   32'(timeout_count), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int v = 0; v < 9; v++) begin
         set_delay(vecs[v].dly);
         strobe(vecs[v].addr, vecs[v].rd, vecs[v].wr, vecs[v].wdata,
                vecs[v].rd, vecs[v].exp_data, vecs[v].lat);
         chk($sformatf("v%0d_s_rd", v),   32'(s_rd), 32'(vecs[v].exp_srd));
         chk($sformatf("v%0d_s_wr", v),   32'(s_wr), 32'(vecs[v].exp_swr));
         chk($sformatf("v%0d_s_addr", v), s_addr, vecs[v].addr);
         if (vecs[v].wr) chk($sformatf("v%0d_s_wr_data", v), s_wr_data, vecs[v].wdata);
         drain();
         exp_to += vecs[v].to;
         chk($sformatf("v%0d_timeouts", v), 32'(timeout_count), 32'(exp_to));
      end
      chk("no_overrun_yet", 32'(rd_overrun), 32'h0);

      // Second read two cycles into a pending one is dropped and flagged.
      set_delay(5);
      strobe(32'h1000_0000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2024_0611, 7);
      strobe(32'h1000_0004, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 0);
      chk("overrun_no_s_rd", 32'(s_rd), 32'h0);
      drain();
      chk("overrun_flag", 32'(rd_overrun), 32'h1);

      // Write forwarded while a read is outstanding; the read still completes.
      strobe(32'h1000_0008, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2024_0611, 7);
      strobe(32'h2000_0010, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0, 0);
      chk("wr_in_wait_s_wr",   32'(s_wr), 32'h4);
      chk("wr_in_wait_data",   s_wr_data, 32'hA5A5_0001);
      chk("wr_in_wait_addr",   s_addr, 32'h2000_0010);
      drain();
      chk("wr_in_wait_timeouts", 32'(timeout_count), 32'(exp_to));
      chk("overrun_sticky",    32'(rd_overrun), 32'h1);

      // Reset in the middle of WAIT: everything clears, the late slave answer is ignored.
      set_delay(3);
      strobe(32'h3000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 0);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_s_rd",     32'(s_rd), 32'h0);
      chk("midrst_s_addr",   s_addr, 32'h0);
      chk("midrst_rd_data",  h_rd_data, 32'h0);
      chk("midrst_overrun",  32'(rd_overrun), 32'h0);
      chk("midrst_timeouts", 32'(timeout_count), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      begin
         int seen = 0;
         repeat (8) begin
            @(negedge clk);
            if (h_rd_data_valid) seen++;
         end
         chk("midrst_no_response", 32'(seen), 32'h0);
      end

      // Normal operation resumes after reset.
      set_delay(1);
      strobe(32'h1000_0004, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2024_0611, 3);
      chk("post_rst_s_rd", 32'(s_rd), 32'h2);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
